// File: rtl/cdb_arbiter_if.sv
// Bundle between functional-unit requesters, the CDB arbiter and the broadcast consumers.
// The master modport is the arbiter side; the slave modport is the requester/consumer side.
interface cdb_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 5
);
  localparam int SRC_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*TAG_WIDTH-1:0]  req_tag;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          cdb_valid;
  logic [TAG_WIDTH-1:0]          cdb_tag;
  logic [DATA_WIDTH-1:0]         cdb_data;
  logic [SRC_W-1:0]              cdb_src;

  modport master (
    input  req_valid, req_tag, req_data,
    output req_ready, cdb_valid, cdb_tag, cdb_data, cdb_src
  );

  modport slave (
    output req_valid, req_tag, req_data,
    input  req_ready, cdb_valid, cdb_tag, cdb_data, cdb_src
  );
endinterface

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter funnelling functional-unit results onto a single common data bus.
// Define CDB_ARB_OUT_REG_EN to register the cdb_* outputs (1-cycle latency from the accept edge).
module cdb_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int DATA_WIDTH     = 32,
  parameter int ROB_DEPTH_BITS = 5,
  parameter int TAG_WIDTH      = ROB_DEPTH_BITS
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  cdb_arbiter_if.master bus
);
  localparam int SRC_W = $clog2(NUM_REQ);
  localparam logic [SRC_W-1:0] LAST_IDX = SRC_W'(NUM_REQ - 1);

  logic [SRC_W-1:0]      r_rr_ptr;
  logic                  w_gvalid;
  logic [SRC_W-1:0]      w_gidx;
  logic [SRC_W-1:0]      w_idx;
  logic [NUM_REQ-1:0]    w_grant;
  logic [TAG_WIDTH-1:0]  w_tag;
  logic [DATA_WIDTH-1:0] w_data;

  // Search upward from r_rr_ptr with wrap; reset and flush suppress every grant.
  always_comb begin
    w_gvalid = 1'b0;
    w_gidx   = '0;
    w_idx    = '0;
    if (rst_n && !flush) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        w_idx = SRC_W'((int'(r_rr_ptr) + k) % NUM_REQ);
        if (!w_gvalid && bus.req_valid[w_idx]) begin
          w_gvalid = 1'b1;
          w_gidx   = w_idx;
        end else begin
          w_gvalid = w_gvalid;
        end
      end
    end else begin
      w_gvalid = 1'b0;
    end
  end

  // One-hot grant and result mux; everything is zero when nobody is granted.
  always_comb begin
    w_grant = '0;
    w_tag   = '0;
    w_data  = '0;
    if (w_gvalid) begin
      w_grant[w_gidx] = 1'b1;
      w_tag  = bus.req_tag[int'(w_gidx)*TAG_WIDTH +: TAG_WIDTH];
      w_data = bus.req_data[int'(w_gidx)*DATA_WIDTH +: DATA_WIDTH];
    end else begin
      w_grant = '0;
    end
  end

  assign bus.req_ready = w_grant;

  // Pointer moves just past the winner; it holds on idle and flush cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr <= '0;
    end else if (w_gvalid) begin
      r_rr_ptr <= (w_gidx == LAST_IDX) ? '0 : w_gidx + SRC_W'(1);
    end else begin
      r_rr_ptr <= r_rr_ptr;
    end
  end

`ifdef CDB_ARB_OUT_REG_EN
  logic                  r_cdb_valid;
  logic [TAG_WIDTH-1:0]  r_cdb_tag;
  logic [DATA_WIDTH-1:0] r_cdb_data;
  logic [SRC_W-1:0]      r_cdb_src;

  // Broadcast stage; a flush empties it so a stale result never reaches the ROB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cdb_valid <= 1'b0;
      r_cdb_tag   <= '0;
      r_cdb_data  <= '0;
      r_cdb_src   <= '0;
    end else if (flush) begin
      r_cdb_valid <= 1'b0;
      r_cdb_tag   <= '0;
      r_cdb_data  <= '0;
      r_cdb_src   <= '0;
    end else begin
      r_cdb_valid <= w_gvalid;
      r_cdb_tag   <= w_tag;
      r_cdb_data  <= w_data;
      r_cdb_src   <= w_gidx;
    end
  end

  // A registered result is still killed in the flush cycle itself.
  assign bus.cdb_valid = r_cdb_valid & ~flush;
  assign bus.cdb_tag   = flush ? '0 : r_cdb_tag;
  assign bus.cdb_data  = flush ? '0 : r_cdb_data;
  assign bus.cdb_src   = flush ? '0 : r_cdb_src;
`else
  assign bus.cdb_valid = w_gvalid;
  assign bus.cdb_tag   = w_tag;
  assign bus.cdb_data  = w_data;
  assign bus.cdb_src   = w_gidx;
`endif
endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: directed scenarios followed by random traffic,
// flushes and a mid-stream reset, all checked against a round-robin reference model.
module tb_cdb_arbiter;
  localparam int NR = 4;
  localparam int DW = 32;
  localparam int TW = 5;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;

  always #5 clk = ~clk;

  cdb_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW), .TAG_WIDTH(TW)) bus ();

  cdb_arbiter #(
    .NUM_REQ(NR), .DATA_WIDTH(DW), .ROB_DEPTH_BITS(TW), .TAG_WIDTH(TW)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .flush(flush),
    .bus  (bus)
  );

  typedef struct packed {
    logic [NR-1:0] ready;
    logic          v;
    logic [TW-1:0] tag;
    logic [DW-1:0] data;
    logic [1:0]    src;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  logic [NR-1:0] s_valid;
  logic [TW-1:0] s_tag  [NR];
  logic [DW-1:0] s_data [NR];

  int   m_ptr  = 0;
  int   m_gnt  = -1;
  exp_t m_prev = '0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endfunction

  // Drive one cycle of inputs, predict the response, then advance to just after the next edge.
  task automatic step(input logic rv, input logic fl);
    exp_t cur;
    exp_t e;
    rst_n = rv;
    flush = fl;
    bus.req_valid = s_valid;
    for (int i = 0; i < NR; i++) begin
      bus.req_tag[i*TW +: TW]  = s_tag[i];
      bus.req_data[i*DW +: DW] = s_data[i];
    end
    cur   = '0;
    m_gnt = -1;
    if (!rv) begin
      m_ptr  = 0;
      m_prev = '0;
    end else if (!fl) begin
      for (int k = 0; k < NR; k++) begin
        if (m_gnt < 0 && s_valid[(m_ptr + k) % NR]) m_gnt = (m_ptr + k) % NR;
      end
    end
    if (m_gnt >= 0) begin
      cur.ready[m_gnt] = 1'b1;
      cur.v    = 1'b1;
      cur.tag  = s_tag[m_gnt];
      cur.data = s_data[m_gnt];
      cur.src  = 2'(m_gnt);
      m_ptr    = (m_gnt + 1) % NR;
    end
    e = cur;
`ifdef CDB_ARB_OUT_REG_EN
    e.v    = fl ? 1'b0 : m_prev.v;
    e.tag  = fl ? '0 : m_prev.tag;
    e.data = fl ? '0 : m_prev.data;
    e.src  = fl ? '0 : m_prev.src;
    m_prev = cur;
`endif
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic new_req(input int i);
    s_valid[i] = 1'b1;
    s_tag[i]   = TW'($urandom);
    s_data[i]  = $urandom;
  endtask

  // Requesters hold until accepted, then retire or issue a fresh result.
  task automatic retire();
    for (int i = 0; i < NR; i++) begin
      if (m_gnt == i) begin
        if ($urandom_range(1, 0) == 1) new_req(i);
        else s_valid[i] = 1'b0;
      end else if (!s_valid[i] && $urandom_range(1, 0) == 1) begin
        new_req(i);
      end
    end
  endtask

  // Monitor: compare every sampled cycle against the oldest prediction.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("req_ready", 64'(bus.req_ready), 64'(e.ready));
      chk("cdb_valid", 64'(bus.cdb_valid), 64'(e.v));
      chk("cdb_tag",   64'(bus.cdb_tag),   64'(e.tag));
      chk("cdb_data",  64'(bus.cdb_data),  64'(e.data));
      chk("cdb_src",   64'(bus.cdb_src),   64'(e.src));
    end
  end

  initial begin
    for (int i = 0; i < NR; i++) begin
      s_valid[i] = 1'b1;
      s_tag[i]   = TW'(i + 1);
      s_data[i]  = 32'hA000_0000 + DW'(i);
    end
    bus.req_valid = '0;
    bus.req_tag   = '0;
    bus.req_data  = '0;
    @(posedge clk);
    #1;

    repeat (3) step(1'b0, 1'b0);
    repeat (5) step(1'b1, 1'b0);

    s_valid = 4'b0000;
    repeat (10) step(1'b1, 1'b0);

    s_valid   = 4'b0100;
    s_tag[2]  = 5'd5;
    s_data[2] = 32'hDEAD_BEEF;
    step(1'b1, 1'b0);
    s_valid = 4'b0000;
    step(1'b1, 1'b0);

    s_valid = 4'b1010;
    step(1'b1, 1'b0);
    s_valid = 4'b0010;
    step(1'b1, 1'b0);

    s_valid = 4'b0011;
    step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    s_valid = 4'b0010;
    step(1'b1, 1'b0);
    s_valid = 4'b0000;
    step(1'b1, 1'b0);

    for (int c = 0; c < 300; c++) begin
      step((c >= 150 && c < 152) ? 1'b0 : 1'b1, ($urandom_range(7, 0) == 0) ? 1'b1 : 1'b0);
      retire();
    end

    s_valid = 4'b0000;
    repeat (3) step(1'b1, 1'b0);
    @(negedge clk);
    #1;
    chk("scoreboard_drain", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, meaning the number of functional-unit requesters (2..8).
REQ-002 SHALL have parameter DATA_WIDTH, default 32, meaning the broadcast result width.
REQ-003 SHALL have parameter TAG_WIDTH, default ROB_DEPTH_BITS, meaning the ROB entry tag width.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 flush  in  1  branch-mispredict flush, same-cycle pulse.
REQ-007 req_valid  in  NUM_REQ  per-requester result valid.
REQ-008 req_tag  in  NUM_REQ*TAG_WIDTH  per-requester ROB tag, slice i = requester i.
REQ-009 req_data  in  NUM_REQ*DATA_WIDTH  per-requester result, slice i = requester i.
REQ-010 req_ready  out  NUM_REQ  one-hot-or-zero grant; requester i's result is accepted when req_valid[i] & req_ready[i].
REQ-011 cdb_valid  out  1  broadcast valid to ROB/reservation stations.
REQ-012 cdb_tag  out  TAG_WIDTH  broadcast ROB tag.
REQ-013 cdb_data  out  DATA_WIDTH  broadcast result.
REQ-014 cdb_src  out  $clog2(NUM_REQ)  index of the granted requester, for debug/perf.

Function
REQ-015 SHALL grant at most one requester per cycle; req_ready is combinational from req_valid, rr_ptr and flush.
REQ-016 SHALL arbitrate round-robin: search starts at rr_ptr and proceeds upward with wrap from NUM_REQ-1 to 0; the first requester with req_valid set is granted.
REQ-017 SHALL, on a grant to requester g, load rr_ptr with (g+1) mod NUM_REQ at the next edge; with no grant, rr_ptr holds.
REQ-018 SHALL keep req_ready[i] low whenever req_valid[i] is low.
REQ-019 Requesters SHALL hold valid/tag/data stable until accepted; the arbiter relies on this and keeps no per-requester buffering.
REQ-020 SHALL, while flush is high, drive req_ready all-zero and cdb_valid 0, and leave rr_ptr unchanged.
REQ-021 SHALL drive cdb_tag, cdb_data and cdb_src from the granted requester and drive all three to 0 when cdb_valid is 0.
REQ-022 SHALL guarantee that a requester holding req_valid is granted within NUM_REQ cycles in which flush is low.

Reset
REQ-023 SHALL, on rst_n low, asynchronously set rr_ptr to 0 and any output register to 0; while in reset, cdb_valid, cdb_tag, cdb_data, cdb_src and req_ready are all 0.
REQ-024 SHALL, on reset deassertion mid-stream, begin arbitration from requester 0 on the first edge after release.

Configuration
REQ-025 Macro CDB_ARB_OUT_REG_EN SHALL control the output stage; when undefined, cdb_* are combinational from the current grant (0-cycle latency).
REQ-026 With CDB_ARB_OUT_REG_EN defined, cdb_* SHALL be registered (1-cycle latency from the accept edge).
REQ-027 With CDB_ARB_OUT_REG_EN defined, flush SHALL also clear the output register at the next edge and force cdb_valid 0 in the flush cycle, even if a result was registered in the previous cycle.

Verification
REQ-028 Reset: hold rst_n=0 with all req_valid=1 -> req_ready=0, cdb_valid=0; after release, first grant goes to requester 0.
REQ-029 Fairness: NUM_REQ=4 with all four requesters valid continuously -> grants in order 0,1,2,3,0; cdb_src follows the same sequence.
REQ-030 Wrap: rr_ptr=3 with only requesters 1 and 3 valid -> grant 3, then 1; rr_ptr becomes 0, then 2.
REQ-031 Single requester: only requester 2 valid with tag 5 and data 0xDEADBEEF -> cdb_valid=1, cdb_tag=5, cdb_data=0xDEADBEEF, cdb_src=2 in the same cycle (or the next cycle with CDB_ARB_OUT_REG_EN defined).
REQ-032 Flush: flush=1 while requesters 0 and 1 are valid -> no grant and cdb_valid=0; rr_ptr unchanged, so the next cycle grants from the pre-flush pointer.
REQ-033 Idle: all req_valid=0 for 10 cycles -> cdb_valid=0, cdb_tag=0, cdb_data=0, and rr_ptr constant.
